// File: rtl/div_unit_pkg.sv
// Shared pipeline definitions for the execute-stage divider: state
// encoding, datapath width and the stall latency seen by the hazard unit.
package div_unit_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 1;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_BUSY = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU. Produces {hi = remainder,
// lo = quotient} and stalls the pipeline while the iterations run.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               div_stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisorMag;
  logic             quoNeg;
  logic             remNeg;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] stepRem;
  logic [WIDTH-1:0] stepQuo;
  logic             lastIter;

  assign absA = (signed_div && a[WIDTH-1]) ? -a : a;
  assign absB = (signed_div && b[WIDTH-1]) ? -b : b;

  // Stall is combinational so the hazard unit sees it in the cycle start rises.
  assign div_stall = rst & start & ~annul & (state != DIV_DONE);
  assign ready     = (state == DIV_DONE);

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    trial    = {rem, quo[WIDTH-1]};
    diff     = trial - {1'b0, divisorMag};
    stepRem  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    stepQuo  = {quo[WIDTH-2:0], ~diff[WIDTH]};
    lastIter = (cnt == CNT_W'(WIDTH - 1));
  end

  // NOTE: all datapath registers are reset so result reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= DIV_IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      divisorMag <= '0;
      quoNeg     <= 1'b0;
      remNeg     <= 1'b0;
      result     <= '0;
    end else if (annul) begin
      state <= DIV_IDLE;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      case (state)
        DIV_IDLE: begin
          if (start) begin
            rem        <= '0;
            quo        <= absA;
            divisorMag <= absB;
            quoNeg     <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            remNeg     <= signed_div & a[WIDTH-1];
            cnt        <= '0;
            state      <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          rem <= stepRem;
          quo <= stepQuo;
          cnt <= cnt + 1'b1;
          if (lastIter) begin
            result <= {remNeg ? -stepRem : stepRem, quoNeg ? -stepQuo : stepQuo};
            state  <= DIV_DONE;
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the execute stage.
- Executes DIV/DIVU and produces the {hi, lo} pair written to the HI/LO registers.
- Drives div_stallE into the hazard unit, which freezes F/D/E/M/W while the divide runs.
- Radix-2 restoring algorithm: one quotient bit per cycle; signed handling by magnitude conversion.

Parameters:
WIDTH, 32, operand width; the result is 2*WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  a DIV/DIVU instruction is in E; held high until the instruction leaves E
signed_div  in  1  1 = DIV (signed), 0 = DIVU
annul  in  1  cancel the in-flight or requested divide (exception/flush)
a  in  WIDTH  dividend (rs value after forwarding)
b  in  WIDTH  divisor (rt value after forwarding)
div_stall  out  1  to hazard unit as div_stallE
ready  out  1  result valid this cycle
result  out  2*WIDTH  {hi = remainder, lo = quotient}

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE, counter 0, internal registers 0.
  - ready = 0, result = 0.
  - div_stall = 0 while in reset.
- States: IDLE, BUSY, DONE.
- div_stall = start & ~annul & (state != DONE). It is combinational and must be valid in the same cycle start rises.
- IDLE:
  - On start & ~annul: latch |a| and |b| (two's-complement negate when signed_div and the operand MSB is 1).
  - Also latch quotient-sign = a[MSB]^b[MSB] and remainder-sign = a[MSB], both gated by signed_div.
  - Clear the partial remainder and counter, then go to BUSY.
- BUSY, one iteration per edge:
  - Shift the {rem, quo} pair left by 1.
  - Trial-subtract |b| from the upper half using a (WIDTH+1)-bit difference.
  - If the difference is non-negative, keep the difference and set quo LSB = 1.
  - After WIDTH iterations (counter = WIDTH-1 at the edge), apply sign fix-up: negate quo if quotient-sign, negate rem if remainder-sign.
  - Register result and go to DONE.
- DONE:
  - ready = 1 and div_stall = 0; result is held stable.
  - Next edge goes to IDLE, with ready low from then on.
  - The pipeline advances on that same edge, so HI/LO capture result.
- Latency, start first high in IDLE at cycle n:
  - div_stall is high in cycles n through n+WIDTH (33 cycles for WIDTH = 32).
  - ready is high in cycle n+WIDTH+1 only.
- result holds its last value until the next completion; it is not cleared on return to IDLE.
- Back-to-back divides: if start is still high in IDLE (a new divide has entered E), a fresh operation starts immediately. There are no lost or duplicated operations.
- Divide by zero (b = 0):
  - Runs the full WIDTH cycles.
  - Unsigned: lo = all ones, hi = a.
  - Signed: the sign fix-up is applied to the raw all-ones/|a| result, giving lo = 1 if a < 0 else all ones, and hi = a.
  - No trap is raised.
- Signed overflow: 0x80000000 / -1 gives lo = 0x80000000, hi = 0.
- annul:
  - Synchronous and highest priority.
  - From any state, the next state is IDLE, ready stays 0 and result is unchanged.
  - annul with start in IDLE does not launch an operation.
- Operand inputs are sampled only at launch. Changes to a/b during BUSY have no effect.

Decomposition:
- Shared package, pipeline defs:
  - div state encoding (IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10).
  - DIV_WIDTH = 32.
  - DIV_LATENCY = DIV_WIDTH + 1 (stall cycles) for bench and hazard checks.
- Sub-modules: none required. The iteration step and the negate helpers are small enough to stay inline.

Test Plan:
- Unsigned 100/7, start held high: div_stall high exactly 33 cycles; ready for 1 cycle with lo = 14, hi = 2; IDLE afterwards.
- Signed -7/2 (a = 0xFFFFFFF9, b = 2): lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Signed 7/-2: lo = 0xFFFFFFFD, hi = 1.
- Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. Unsigned 0x12345678 / 0: lo = 0xFFFFFFFF, hi = 0x12345678 after 33 stall cycles.
- Back-to-back: 50/5 then 9/4 with start continuously high across the DONE cycle: two ready pulses 34 cycles apart, results {0, 10} then {1, 2}.
- annul asserted in BUSY cycle 10: next cycle is IDLE with div_stall 0 and no ready pulse; result keeps its previous value; a subsequent divide completes correctly.
- rst pulled low mid-BUSY, off-edge: outputs go to 0 immediately; after release, start launches a normal 33-cycle divide.
